// File: rtl/timer_ctrl_master.sv
// Avalon-MM master that programs, services and samples a 16-bit-register interval timer.
// All outputs, bus signals included, are registered from the next-state decode.
module timer_ctrl_master #(
    parameter logic CONTINUOUS = 1'b1,
    parameter int   IRQ_GUARD  = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cfg_start,
    input  logic [31:0] cfg_period,
    input  logic        cfg_stop,
    input  logic        snap_req,
    output logic        busy,
    output logic        running,
    output logic        tick,
    output logic [31:0] tick_count,
    output logic [31:0] snapshot,
    output logic        snap_valid,
    output logic [2:0]  avm_address,
    output logic        avm_write,
    output logic        avm_read,
    output logic [15:0] avm_writedata,
    input  logic [15:0] avm_readdata,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    input  logic        irq,
    output logic [3:0]  dbg_state
);

    typedef enum logic [3:0] {
        IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR_ST, GUARD,
        SNAP_W, SNAP_RL, WAIT_L, SNAP_RH, WAIT_H, STOP_W
    } state_t;

    localparam logic [15:0] CTRL_START = 16'h0005 | {14'd0, CONTINUOUS, 1'b0};
    localparam logic [15:0] CTRL_STOP  = 16'h0008;
    localparam logic [7:0]  GUARD_LOAD = (IRQ_GUARD > 0) ? 8'(IRQ_GUARD - 1) : 8'd0;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] period_q;
    logic [31:0] period_src;
    logic [15:0] snap_lo;
    logic [7:0]  guard_cnt;
    logic        wr_acc;
    logic        rd_acc;

    // A transfer is accepted in the cycle its request is high and waitrequest is low;
    // until then address, data and request stay frozen because state_nxt equals state.
    assign wr_acc     = avm_write & ~avm_waitrequest;
    assign rd_acc     = avm_read & ~avm_waitrequest;
    assign period_src = (state == IDLE) ? cfg_period : period_q;
    assign dbg_state  = state;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (cfg_start) state_nxt = WR_PL;
            WR_PL:   if (wr_acc) state_nxt = WR_PH;
            WR_PH:   if (wr_acc) state_nxt = WR_CTRL;
            WR_CTRL: if (wr_acc) state_nxt = RUN;
            RUN: begin
                if (cfg_stop)      state_nxt = STOP_W;
                else if (irq)      state_nxt = CLR_ST;
                else if (snap_req) state_nxt = SNAP_W;
            end
            CLR_ST:  if (wr_acc) state_nxt = (IRQ_GUARD > 0) ? GUARD : RUN;
            GUARD:   if (guard_cnt == 8'd0) state_nxt = RUN;
            SNAP_W:  if (wr_acc) state_nxt = SNAP_RL;
            SNAP_RL: if (rd_acc) state_nxt = WAIT_L;
            WAIT_L:  if (avm_readdatavalid) state_nxt = SNAP_RH;
            SNAP_RH: if (rd_acc) state_nxt = WAIT_H;
            WAIT_H:  if (avm_readdatavalid) state_nxt = RUN;
            STOP_W:  if (wr_acc) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            busy          <= 1'b0;
            running       <= 1'b0;
            tick          <= 1'b0;
            tick_count    <= 32'd0;
            snapshot      <= 32'd0;
            snap_valid    <= 1'b0;
            avm_address   <= 3'd0;
            avm_write     <= 1'b0;
            avm_read      <= 1'b0;
            avm_writedata <= 16'd0;
            period_q      <= 32'd0;
            snap_lo       <= 16'd0;
            guard_cnt     <= 8'd0;
        end else begin
            state   <= state_nxt;
            busy    <= !(state_nxt == IDLE || state_nxt == RUN);
            running <= state_nxt inside {RUN, CLR_ST, GUARD, SNAP_W, SNAP_RL,
                                         WAIT_L, SNAP_RH, WAIT_H};
            avm_write <= state_nxt inside {WR_PL, WR_PH, WR_CTRL, CLR_ST, SNAP_W, STOP_W};
            avm_read  <= state_nxt inside {SNAP_RL, SNAP_RH};

            unique case (state_nxt)
                WR_PL:   begin avm_address <= 3'd2; avm_writedata <= period_src[15:0];  end
                WR_PH:   begin avm_address <= 3'd3; avm_writedata <= period_q[31:16];   end
                WR_CTRL: begin avm_address <= 3'd1; avm_writedata <= CTRL_START;        end
                STOP_W:  begin avm_address <= 3'd1; avm_writedata <= CTRL_STOP;         end
                SNAP_W:  begin avm_address <= 3'd4; avm_writedata <= 16'd0;             end
                SNAP_RL: begin avm_address <= 3'd4; avm_writedata <= 16'd0;             end
                SNAP_RH: begin avm_address <= 3'd5; avm_writedata <= 16'd0;             end
                default: begin avm_address <= 3'd0; avm_writedata <= 16'd0;             end
            endcase

            tick       <= (state == CLR_ST) && wr_acc;
            snap_valid <= (state == WAIT_H) && avm_readdatavalid;

            if (state == IDLE && cfg_start) begin
                period_q   <= cfg_period;
                tick_count <= 32'd0;
            end else if (state == CLR_ST && wr_acc) begin
                tick_count <= tick_count + 32'd1;
            end

            if (state == CLR_ST)
                guard_cnt <= GUARD_LOAD;
            else if (state == GUARD && guard_cnt != 8'd0)
                guard_cnt <= guard_cnt - 8'd1;

            if (state == WAIT_L && avm_readdatavalid)
                snap_lo <= avm_readdata;
            if (state == WAIT_H && avm_readdatavalid)
                snapshot <= {avm_readdata, snap_lo};
        end
    end

endmodule

// File: doc/timer_ctrl_master.md
# timer_ctrl_master

Avalon-MM master that programs, services and samples a 16-bit-register interval timer peripheral on behalf of hardware logic, with no CPU involved. On a start command it writes the 32-bit period and the control word. While the timer runs it acknowledges each interrupt by clearing the status register, counts the ticks, and performs counter snapshot reads on request. It sits between fabric-side control logic and the timer's s1 slave port, as the initiator end of that register interface.

## Interface
- `CONTINUOUS`, 1: value of control bit 1 (CONT) written on start.
- `IRQ_GUARD`, 2: cycles `irq` is ignored after a status-clear write is accepted (covers interconnect latency).
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cfg_start`  in  1  one-cycle pulse; program and start the timer with `cfg_period`.
- `cfg_period`  in  32  timer load value (timeout every value+1 clocks); sampled with `cfg_start`.
- `cfg_stop`  in  1  one-cycle pulse; stop the timer.
- `snap_req`  in  1  one-cycle pulse; request a counter snapshot.
- `busy`  out  1  high whenever the FSM is not in IDLE or RUN.
- `running`  out  1  high in RUN and in all service/snapshot states.
- `tick`  out  1  one-cycle pulse per serviced timeout.
- `tick_count`  out  32  number of serviced timeouts since the last start; wraps.
- `snapshot`  out  32  last snapshot value.
- `snap_valid`  out  1  one-cycle pulse when `snapshot` updates.
- `avm_address`  out  3  timer word offset: 0 status, 1 control, 2 period_l, 3 period_h, 4 snap_l, 5 snap_h.
- `avm_write`, `avm_read`  out  1  transfer requests.
- `avm_writedata`  out  16  write data.
- `avm_readdata`  in  16  read data.
- `avm_waitrequest`  in  1  stall; the master holds all outputs stable while it is high.
- `avm_readdatavalid`  in  1  read data qualifier (pipelined reads, 1 outstanding max).
- `irq`  in  1  timer interrupt, level.

## Operation
- States: IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR_ST, GUARD, SNAP_W, SNAP_RL, WAIT_L, SNAP_RH, WAIT_H, STOP_W.
- IDLE + `cfg_start` → latch period, clear `tick_count` → WR_PL (addr 2, period[15:0]) → WR_PH (addr 3, period[31:16]) → WR_CTRL (addr 1, data 0x0005 | CONTINUOUS<<1) → RUN.
- Each write state advances on the cycle in which `avm_write` is high and `avm_waitrequest` is low (accept).
- RUN priority: `cfg_stop` > `irq` > `snap_req`.
- `cfg_stop` → STOP_W (addr 1, data 0x0008) → IDLE.
- `irq` → CLR_ST (addr 0, data 0x0000). On accept: `tick` pulses and `tick_count` increments. Then GUARD for IRQ_GUARD cycles → RUN.
- `snap_req` → SNAP_W (addr 4, data 0) → SNAP_RL (read addr 4) → WAIT_L (capture low on `avm_readdatavalid`) → SNAP_RH (read addr 5) → WAIT_H (capture high; `snapshot` updates and `snap_valid` pulses) → RUN.
- Commands that arrive in a state other than the one that accepts them are dropped and not queued: `cfg_start` outside IDLE, `cfg_stop`/`snap_req` outside RUN. `irq` is level, so a timeout that arrives during a snapshot is serviced on return to RUN.
- `tick_count` wraps from 0xFFFFFFFF to 0.

## Timing
- Reset (async): state IDLE. All outputs are 0: `busy`, `running`, `tick`, `tick_count`, `snapshot`, `snap_valid`, `avm_*`. Reset asserted mid-transfer drops `avm_write`/`avm_read` immediately.
- Outputs are registered. A command pulse at edge N drives the first `avm_write` at N+1.
- Start sequence with zero wait states: 3 transfers, RUN is reached 4 cycles after `cfg_start`.
- `avm_read` is deasserted on accept. `readdatavalid` may arrive 1 or more cycles later.
- `avm_read` and `avm_write` are never high together. At most one read is outstanding.
- `tick` coincides with the cycle after CLR_ST accept. `snap_valid` follows the high-half `readdatavalid` by 1 cycle.
- Waitrequest held high indefinitely: the FSM holds its state and bus outputs.

## Test plan
- Reset, then `cfg_start` with period 0x00192D4F, zero waits → writes (2,0x2D4F), (3,0x0019), (1,0x0007) on 3 consecutive cycles; `running`=1.
- In RUN, assert `irq` until status write accepted → one write (0,0x0000), `tick`=1 one cycle, `tick_count`=1. `irq` held 1 extra cycle produces no second tick.
- `snap_req`, slave returns 0x1234 then 0x0056 with readdatavalid latency 1 → write addr 4, reads 4 then 5; `snapshot`=0x00561234, `snap_valid` pulses once.
- `avm_waitrequest` high 5 cycles during WR_PH → address/data stable throughout; WR_CTRL starts the cycle after release.
- `cfg_stop` and `irq` in the same RUN cycle → (1,0x0008) issued, no status clear, IDLE. `tick_count` is preloaded to 0xFFFFFFFF, then one tick → 0.
- `reset_n` low during SNAP_RL with `avm_read`=1 → `avm_read`=0 at once, all outputs 0. `cfg_start` during RUN is ignored.
